// File: rtl/bist_scheduler.sv
// Round-robin scheduler sharing one BIST controller between NREQ requesters:
// grants, starts the run, watches for completion, checks the MISR signature, reports.
module bist_scheduler #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned SIGW    = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned FCW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            pass,
  output logic            timeout_err,
  output logic            busy,
  output logic            bist_start,
  input  logic            bist_end,
  input  logic [SIGW-1:0] signature,
  input  logic [SIGW-1:0] golden,
  output logic [FCW-1:0]  fail_count
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CHECK, S_REPORT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, win_q, win_d, arb_idx;
  logic            arb_found;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            pass_q, pass_d, tmo_q, tmo_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  int unsigned     cand;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!arb_found && req[PW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    wdog_d   = '0;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    fcnt_d   = fcnt_q;
    unique case (state_q)
      S_IDLE: if (arb_found) begin
        state_d = S_START;
        win_d   = arb_idx;
        gnt_d   = NREQ'(1) << arb_idx;
        pass_d  = 1'b0;
        tmo_d   = 1'b0;
      end
      S_START: state_d = S_WAIT;
      // bist_end takes priority over the watchdog on the limit cycle.
      S_WAIT: begin
        if (bist_end) begin
          state_d = S_CHECK;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          state_d = S_REPORT;
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_CHECK: begin
        state_d = S_REPORT;
        pass_d  = (signature == golden);
      end
      S_REPORT: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        if (!pass_q && (fcnt_q != '1)) fcnt_d = fcnt_q + FCW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      wdog_q   <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      wdog_q   <= wdog_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = (state_q != S_IDLE);
  assign bist_start  = (state_q == S_START);
  assign done        = (state_q == S_REPORT) ? gnt_q : '0;
  assign pass        = (state_q == S_REPORT) && pass_q;
  assign timeout_err = (state_q == S_REPORT) && tmo_q;
  assign fail_count  = fcnt_q;

endmodule
